// File: rtl/sw_debounce_sync_if.sv
// sw_debounce_sync_if: switch conditioning bus between the raw pins/software side and the debouncer
interface sw_debounce_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] chg_clr;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] chg_flag;

    modport master (
        output sw_raw,
        output chg_clr,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  chg_flag
    );

    modport slave (
        input  sw_raw,
        input  chg_clr,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output chg_flag
    );
endinterface

// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: per-channel 2-FF synchronizer plus counter debouncer with edge pulses and sticky change flags
module sw_debounce_sync #(
    parameter int                 WIDTH           = 1,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0]   RESET_VAL       = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sw_debounce_sync_if.slave     bus
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_flag;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc;

    assign w_diff       = r_sync2 ^ r_clean;
    assign bus.sw_clean = r_clean;
    assign bus.sw_rise  = r_rise;
    assign bus.sw_fall  = r_fall;
    assign bus.chg_flag = r_flag;

    // Synchronize raw pins, flip accepted channels, and register pulses and sticky flags (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_clean <= RESET_VAL;
            r_rise  <= '0;
            r_fall  <= '0;
            r_flag  <= '0;
        end else begin
            r_sync1 <= bus.sw_raw;
            r_sync2 <= r_sync1;
            r_clean <= r_clean ^ w_acc;
            r_rise  <= w_acc & r_sync2;
            r_fall  <= w_acc & ~r_sync2;
            r_flag  <= w_acc | (r_flag & ~bus.chg_clr);
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_ch
            state_t          r_state;
            state_t          w_state_nxt;
            logic [CW-1:0]   r_cnt;
            logic [CW-1:0]   w_cnt_cur;
            logic [CW-1:0]   w_cnt_nxt;
            logic            w_accept;

            assign w_acc[g] = w_accept;

            // Qualify a differing sample run; any sample matching sw_clean drops back to STABLE
            always_comb begin
                w_cnt_cur   = (r_state == ST_PENDING) ? r_cnt : '0;
                w_accept    = w_diff[g] && (w_cnt_cur == LAST);
                w_state_nxt = (w_diff[g] && !w_accept) ? ST_PENDING : ST_STABLE;
                w_cnt_nxt   = (w_state_nxt == ST_PENDING) ? w_cnt_cur + CW'(1) : '0;
            end

            // Per-channel state and qualification counter
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end
        end
    endgenerate
endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
- Conditioning stage directly upstream of the switch PIO slave. Takes raw, asynchronous, bouncy slide-switch/key inputs.
- Per channel: 2-FF synchronizer, then a counter-based debouncer.
- Produces clean, glitch-free levels for the PIO in_port, plus one-cycle rise/fall pulses and sticky per-channel change flags for software polling.

Parameters:
- WIDTH, 1, number of independent switch channels (>=1).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronized input must hold its new value before it is accepted (1 ms at 50 MHz); legal range >=1.
- RESET_VAL, 0, WIDTH-bit value loaded into synchronizers and sw_clean on reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sw_raw  in  WIDTH  raw switch pins, asynchronous to clk.
- sw_clean  out  WIDTH  debounced level; drives PIO in_port.
- sw_rise  out  WIDTH  one-cycle pulse when sw_clean[i] goes 0->1.
- sw_fall  out  WIDTH  one-cycle pulse when sw_clean[i] goes 1->0.
- chg_flag  out  WIDTH  sticky: set on any accepted transition of channel i.
- chg_clr  in  WIDTH  per-channel clear for chg_flag, level-sampled each cycle.

Behaviour:
- Reset: clk is clock, reset_n is asynchronous active-low reset. While reset_n=0:
  - sync1, sync2, sw_clean = RESET_VAL.
  - All counters = 0.
  - sw_rise, sw_fall, chg_flag = 0.
  - Reset deassertion takes effect on the next clk edge. No pulses are produced afterward if sw_raw == RESET_VAL.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1, every edge. sync2 is the only raw-derived signal used downstream.
- Counter: one per channel, width ceil(log2(DEBOUNCE_CYCLES+1)), unsigned, never wraps.
- Per-channel FSM, 2 states:
  - STABLE: sync2 == sw_clean, cnt = 0.
  - PENDING: sync2 != sw_clean. Each edge:
    - if sync2 == sw_clean, cnt <= 0 and go to STABLE (glitch rejected, no output change);
    - else if cnt == DEBOUNCE_CYCLES-1, then sw_clean <= sync2, cnt <= 0, pulse fires, go to STABLE;
    - else cnt <= cnt+1.
- Latency:
  - sw_raw changes before edge k and holds: sync2 updates at edge k+1; sw_clean updates at edge k+1+DEBOUNCE_CYCLES.
  - sw_rise/sw_fall are registered at that same edge and are high exactly one cycle.
- DEBOUNCE_CYCLES=1: sw_clean follows sync2 with 1 cycle delay (total 2 cycles from sw_raw).
- Bounce: any sync2 sample equal to the old sw_clean restarts qualification from 0. A pulse train shorter than DEBOUNCE_CYCLES never propagates.
- Channels are fully independent; simultaneous transitions on several channels pulse in the same cycle.
- sw_rise and sw_fall of one channel are never both 1 in a cycle.
- chg_flag[i]:
  - set when sw_rise[i] | sw_fall[i] is registered;
  - cleared when chg_clr[i]=1;
  - if set and clear coincide, set wins (no lost event);
  - holds otherwise.
- Reset mid-qualification aborts it: counters cleared, sw_clean returns to RESET_VAL, no pulse.

Test Plan:
- Use WIDTH=2, DEBOUNCE_CYCLES=4, RESET_VAL=2'b00 for all scenarios.
- Reset release, sw_raw=00 held 20 cycles -> sw_clean=00; no rise/fall pulses; chg_flag=00.
- sw_raw[0] 0->1 before edge 10, held -> sw_clean[0]=1 after edge 15; sw_rise[0]=1 for exactly the cycle after edge 15; chg_flag[0]=1 from then on.
- sw_raw[0] bounce 1,0,1,1,0 (one cycle each), then steady 0 -> sw_clean[0] stays 0; no pulses.
- Both channels 1->0 on the same edge after being stable 1 -> sw_fall=11 in a single common cycle; sw_clean=00.
- chg_flag[1]=1; assert chg_clr[1] on the same edge a new sw_rise[1] is registered -> chg_flag[1] stays 1. A later chg_clr[1] alone -> 0 next cycle.
- sw_raw[0]=1 held 3 cycles past sync, then reset_n pulsed low 1 cycle -> sw_clean=00, no pulse. After release with sw_raw[0]=1, sw_clean[0]=1 at 2+4 cycles.
